// File: rtl/fifo_read_ctrl_if.sv
// Read-side bundle of the async FIFO: synchronised write pointer, memory port,
// read pointers, status, and the output valid/ready stream.
interface fifo_read_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH:0]   g_wptr_sync;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [ADDR_WIDTH:0]   b_rptr;
  logic [ADDR_WIDTH:0]   g_rptr;
  logic                  r_en;
  logic                  empty;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [ADDR_WIDTH:0]   level;
  logic                  ptr_err;

  modport master (
    input  g_wptr_sync, mem_rdata, m_ready,
    output b_rptr, g_rptr, r_en, empty, m_data, m_valid, level, ptr_err
  );

  modport slave (
    output g_wptr_sync, mem_rdata, m_ready,
    input  b_rptr, g_rptr, r_en, empty, m_data, m_valid, level, ptr_err
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-domain controller: read pointers, registered empty/level,
// sticky pointer-error flag and a single-register valid/ready output stage.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input logic              rclk,
  input logic              rrst,
  fifo_read_ctrl_if.master bus
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0]         b_rptr_r;
  logic [PW-1:0]         g_rptr_r;
  logic                  empty_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic                  m_valid_r;
  logic [PW-1:0]         level_r;
  logic                  ptr_err_r;

  logic                  r_en_s;
  logic [PW-1:0]         b_rptr_next_s;
  logic [PW-1:0]         g_rptr_next_s;
  logic [PW-1:0]         b_wptr_bin_s;
  logic [PW-1:0]         level_next_s;

  // Pop whenever data exists and the output register is free or draining.
  always_comb begin
    r_en_s        = 1'b0;
    b_rptr_next_s = b_rptr_r;
    if (!empty_r && (!m_valid_r || bus.m_ready)) begin
      r_en_s        = 1'b1;
      b_rptr_next_s = b_rptr_r + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      r_en_s        = 1'b0;
      b_rptr_next_s = b_rptr_r;
    end
    g_rptr_next_s = bin2gray(b_rptr_next_s);
    b_wptr_bin_s  = gray2bin(bus.g_wptr_sync);
    level_next_s  = b_wptr_bin_s - b_rptr_next_s;
  end

  // Pointer, status and output-stage registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      b_rptr_r  <= {PW{1'b0}};
      g_rptr_r  <= {PW{1'b0}};
      empty_r   <= 1'b1;
      m_data_r  <= {DATA_WIDTH{1'b0}};
      m_valid_r <= 1'b0;
      level_r   <= {PW{1'b0}};
      ptr_err_r <= 1'b0;
    end else begin
      b_rptr_r <= b_rptr_next_s;
      g_rptr_r <= g_rptr_next_s;
      // Compared against the incoming pointer so a final pop sets empty at once.
      empty_r  <= (g_rptr_next_s == bus.g_wptr_sync);
      level_r  <= level_next_s;
      if (level_next_s > DEPTH_L) begin
        ptr_err_r <= 1'b1;
      end
      if (r_en_s) begin
        m_data_r  <= bus.mem_rdata;
        m_valid_r <= 1'b1;
      end else if (m_valid_r && bus.m_ready) begin
        m_valid_r <= 1'b0;
      end
    end
  end

  assign bus.b_rptr  = b_rptr_r;
  assign bus.g_rptr  = g_rptr_r;
  assign bus.r_en    = r_en_s;
  assign bus.empty   = empty_r;
  assign bus.m_data  = m_data_r;
  assign bus.m_valid = m_valid_r;
  assign bus.level   = level_r;
  assign bus.ptr_err = ptr_err_r;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: directed scenarios plus randomized
// traffic compared against a queue/counter model of the read side.
module tb_fifo_read_ctrl;
  logic rclk = 1'b0;
  logic rrst = 1'b0;
  always #5 rclk = ~rclk;

  fifo_read_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();
  fifo_read_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
    .rclk(rclk), .rrst(rrst), .bus(bus.master)
  );

  logic [7:0] mem [64];
  assign bus.mem_rdata = mem[bus.b_rptr[5:0]];

  int checks = 0;
  int errors = 0;

  // model: total words written / popped as plain integers
  int   m_wptr, m_rptr, m_level;
  bit   m_valid, m_empty, m_err, m_pop;
  logic [7:0] m_data;
  logic ren_seen;

  function automatic logic [6:0] gray7(input int b);
    logic [6:0] v;
    v = 7'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic do_reset();
    rrst = 1'b1;
    bus.g_wptr_sync = 7'd0;
    bus.m_ready = 1'b0;
    m_wptr = 0; m_rptr = 0; m_level = 0;
    m_valid = 0; m_empty = 1; m_err = 0; m_pop = 0;
    m_data = 8'h00;
    @(negedge rclk);
    rrst = 1'b0;
    @(posedge rclk); #1;
  endtask

  // advance the write pointer by wadd (optionally filling memory), run one edge
  task automatic step(input int wadd, input bit fill, input bit rdy);
    int lvl;
    if (fill) begin
      for (int k = 0; k < wadd; k++) mem[(m_wptr + k) & 63] = 8'($urandom);
    end
    m_wptr = m_wptr + wadd;
    bus.g_wptr_sync = gray7(m_wptr);
    bus.m_ready = rdy;
    @(negedge rclk);
    ren_seen = bus.r_en;
    m_pop = !m_empty && (!m_valid || rdy);
    if (m_pop) begin
      m_data = mem[m_rptr & 63];
      m_valid = 1;
      m_rptr = m_rptr + 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_empty = ((m_rptr & 127) == (m_wptr & 127));
    lvl = (m_wptr - m_rptr) & 127;
    m_level = lvl;
    if (lvl > 64) m_err = 1;
    @(posedge rclk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1'b0);
      checks++;
      if (bus.empty !== 1'b1 || bus.m_valid !== 1'b0 || ren_seen !== 1'b0 ||
          bus.b_rptr !== 7'd0 || bus.level !== 7'd0 || bus.ptr_err !== 1'b0 ||
          bus.g_rptr !== 7'd0 || bus.m_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got empty=%b valid=%b ren=%b b_rptr=%0d level=%0d err=%b want 1 0 0 0 0 0",
                 i, bus.empty, bus.m_valid, ren_seen, bus.b_rptr, bus.level, bus.ptr_err);
      end
    end
  endtask

  task automatic test_stream3();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2;
    do_reset();
    for (int i = 0; i < 3; i++) mem[i] = exp_d[i];
    step(3, 0, 1'b1);
    checks++;
    if (bus.empty !== 1'b0 || bus.m_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream3_empty_fall got empty=%b valid=%b want 0 0", bus.empty, bus.m_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1'b1);
      checks++;
      if (ren_seen !== 1'b1 || bus.m_valid !== 1'b1 || bus.m_data !== exp_d[i]) begin
        errors++;
        $display("FAIL stream3_data %0d got ren=%b valid=%b data=%h want 1 1 %h",
                 i, ren_seen, bus.m_valid, bus.m_data, exp_d[i]);
      end
    end
    checks++;
    if (bus.b_rptr !== 7'd3 || bus.empty !== 1'b1 || bus.g_rptr !== 7'b0000010) begin
      errors++;
      $display("FAIL stream3_end got b_rptr=%0d empty=%b g_rptr=%b want 3 1 0000010",
               bus.b_rptr, bus.empty, bus.g_rptr);
    end
    step(0, 0, 1'b1);
    checks++;
    if (ren_seen !== 1'b0 || bus.m_valid !== 1'b0 || bus.level !== 7'd0 || bus.m_data !== 8'hA2) begin
      errors++;
      $display("FAIL stream3_drain got ren=%b valid=%b level=%0d data=%h want 0 0 0 a2",
               ren_seen, bus.m_valid, bus.level, bus.m_data);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] w [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      w[i] = 8'($urandom);
      mem[i] = w[i];
    end
    step(5, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1'b0);
      checks++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== w[0] || bus.b_rptr !== 7'd1 ||
          bus.level !== 7'd4 || ren_seen !== (i == 0)) begin
        errors++;
        $display("FAIL backpressure_hold cyc %0d got valid=%b data=%h b_rptr=%0d level=%0d ren=%b want 1 %h 1 4 %b",
                 i, bus.m_valid, bus.m_data, bus.b_rptr, bus.level, ren_seen, w[0], (i == 0));
      end
    end
    for (int i = 1; i < 5; i++) begin
      step(0, 0, 1'b1);
      checks++;
      if (ren_seen !== 1'b1 || bus.m_valid !== 1'b1 || bus.m_data !== w[i]) begin
        errors++;
        $display("FAIL backpressure_stream %0d got ren=%b valid=%b data=%h want 1 1 %h",
                 i, ren_seen, bus.m_valid, bus.m_data, w[i]);
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.b_rptr !== 7'd5) begin
      errors++;
      $display("FAIL backpressure_end got empty=%b b_rptr=%0d want 1 5", bus.empty, bus.b_rptr);
    end
  endtask

  task automatic test_wrap();
    int cyc = 0;
    bit seen64 = 0, seen_wrap = 0;
    logic [6:0] prev_b, prev_g;
    do_reset();
    step(8, 1, 1'b1);
    prev_b = bus.b_rptr; prev_g = bus.g_rptr;
    while (m_rptr < 130 && cyc < 300) begin
      step((m_wptr < 138 && (m_wptr - m_rptr) < 8) ? 1 : 0, 1, 1'b1);
      cyc++;
      checks++;
      if (bus.m_valid !== 1'(m_valid) || bus.m_data !== m_data || bus.b_rptr !== 7'(m_rptr) ||
          bus.empty !== 1'(m_empty) || bus.level !== 7'(m_level)) begin
        errors++;
        $display("FAIL wrap_stream cyc %0d got valid=%b data=%h b_rptr=%0d empty=%b level=%0d want %b %h %0d %b %0d",
                 cyc, bus.m_valid, bus.m_data, bus.b_rptr, bus.empty, bus.level,
                 m_valid, m_data, 7'(m_rptr), m_empty, 7'(m_level));
      end
      if (prev_b == 7'd63 && bus.b_rptr == 7'd64) seen64 = 1;
      if (prev_b == 7'd127 && bus.b_rptr == 7'd0 && prev_g == 7'b1000000 && bus.g_rptr == 7'd0) seen_wrap = 1;
      prev_b = bus.b_rptr; prev_g = bus.g_rptr;
    end
    checks++;
    if (m_rptr < 130 || cyc > 140 || !seen64 || !seen_wrap) begin
      errors++;
      $display("FAIL wrap_coverage got pops=%0d cycles=%0d seen64=%b seen_wrap=%b want 130 <=140 1 1",
               m_rptr, cyc, seen64, seen_wrap);
    end
  endtask

  task automatic test_full_error();
    do_reset();
    step(64, 1, 1'b0);
    checks++;
    if (bus.level !== 7'd64 || bus.ptr_err !== 1'b0 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL full_level got level=%0d err=%b empty=%b want 64 0 0", bus.level, bus.ptr_err, bus.empty);
    end
    step(0, 0, 1'b0);
    step(2, 0, 1'b0);
    checks++;
    if (bus.ptr_err !== 1'b1 || bus.level !== 7'd65) begin
      errors++;
      $display("FAIL error_set got err=%b level=%0d want 1 65", bus.ptr_err, bus.level);
    end
    step(-2, 0, 1'b0);
    step(0, 0, 1'b0);
    checks++;
    if (bus.ptr_err !== 1'b1 || bus.level !== 7'd63) begin
      errors++;
      $display("FAIL error_sticky got err=%b level=%0d want 1 63", bus.ptr_err, bus.level);
    end
  endtask

  task automatic test_reset_midstream();
    int cyc = 0;
    do_reset();
    step(20, 1, 1'b1);
    while (m_rptr < 10 && cyc < 50) begin
      step(0, 0, 1'b1);
      cyc++;
    end
    checks++;
    if (bus.b_rptr !== 7'd10 || bus.m_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got b_rptr=%0d valid=%b want 10 1", bus.b_rptr, bus.m_valid);
    end
    #2 rrst = 1'b1;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.b_rptr !== 7'd0 || bus.g_rptr !== 7'd0 ||
        bus.empty !== 1'b1 || bus.level !== 7'd0 || bus.m_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_async got valid=%b b_rptr=%0d g_rptr=%0d empty=%b level=%0d data=%h want 0 0 0 1 0 00",
               bus.m_valid, bus.b_rptr, bus.g_rptr, bus.empty, bus.level, bus.m_data);
    end
    do_reset();
  endtask

  task automatic test_random();
    int wadd;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      wadd = $urandom_range(0, 3);
      if ((m_wptr - m_rptr) + wadd > 64) wadd = 0;
      step(wadd, 1, 1'($urandom_range(0, 3) != 0));
      checks++;
      if (ren_seen !== 1'(m_pop) || bus.m_valid !== 1'(m_valid) || bus.m_data !== m_data ||
          bus.b_rptr !== 7'(m_rptr) || bus.g_rptr !== gray7(m_rptr) || bus.empty !== 1'(m_empty) ||
          bus.level !== 7'(m_level) || bus.ptr_err !== 1'(m_err)) begin
        errors++;
        $display("FAIL random cyc %0d got ren=%b valid=%b data=%h b_rptr=%0d empty=%b level=%0d err=%b want %b %b %h %0d %b %0d %b",
                 i, ren_seen, bus.m_valid, bus.m_data, bus.b_rptr, bus.empty, bus.level, bus.ptr_err,
                 m_pop, m_valid, m_data, 7'(m_rptr), m_empty, 7'(m_level), m_err);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    bus.g_wptr_sync = 7'd0;
    bus.m_ready = 1'b0;
    rrst = 1'b1;
    #3;
    checks++;
    if (bus.empty !== 1'b1 || bus.m_valid !== 1'b0 || bus.b_rptr !== 7'd0) begin
      errors++;
      $display("FAIL reset_state got empty=%b valid=%b b_rptr=%0d want 1 0 0", bus.empty, bus.m_valid, bus.b_rptr);
    end
    test_reset();
    test_stream3();
    test_backpressure();
    test_wrap();
    test_full_error();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
